// File: rtl/cla_seq_adder.sv
// Wide adder/subtractor that streams N nibbles through one shared 4-bit
// carry-lookahead adder, least significant nibble first.

module cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Carries are flattened lookahead terms, not a ripple chain.
    assign c_s[0] = ci;
    assign c_s[1] = g_s[0] | (p_s[0] & ci);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & ci);
    assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & ci);

    assign s  = p_s ^ c_s[3:0];
    assign co = c_s[4];
endmodule

module cla_seq_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sub,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES + 1);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          c_q;
    logic [IW-1:0] idx;

    logic [IW+1:0] bit_idx_s;
    logic [3:0]    cla_a_s;
    logic [3:0]    cla_b_s;
    logic [3:0]    cla_sum_s;
    logic          cla_cout_s;

    assign bit_idx_s = {idx, 2'b00};
    assign cla_a_s   = a_q[bit_idx_s +: 4];
    assign cla_b_s   = b_q[bit_idx_s +: 4];

    cla u_cla (
        .a  (cla_a_s),
        .b  (cla_b_s),
        .ci (c_q),
        .s  (cla_sum_s),
        .co (cla_cout_s)
    );

    // Control FSM, operand/carry latches and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        c_q     <= sub ? 1'b1 : cin;
                        sum     <= '0;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    sum[bit_idx_s +: 4] <= cla_sum_s;
                    c_q <= cla_cout_s;
                    idx <= idx + {{(IW-1){1'b0}}, 1'b1};
                    if (idx == LAST) begin
                        // Overflow: carry into the sign bit differs from carry out.
                        cout    <= cla_cout_s;
                        ovf     <= (a_q[W-1] ^ b_q[W-1] ^ cla_sum_s[3]) ^ cla_cout_s;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder: expected results are queued at start
// and compared when done pulses.

module tb_cla_seq_adder;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_fail = 0;
    logic [W+1:0] exp_q[$];

    cla_seq_adder #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: returns {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic s, input logic [W-1:0] x,
                                           input logic [W-1:0] y, input logic c);
        logic [W-1:0] yy;
        logic [W:0]   full;
        logic         v;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (s ? 1'b1 : c)};
        v    = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        return {v, full};
    endfunction

    // Scoreboard: each done pulse consumes one expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [W+1:0] e;
                e = exp_q.pop_front();
                check("sum", {48'd0, sum}, {48'd0, e[W-1:0]});
                check("cout", {63'd0, cout}, {63'd0, e[W]});
                check("ovf", {63'd0, ovf}, {63'd0, e[W+1]});
            end
        end
    end

    task automatic do_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input bit spam);
        int lat;
        int busy_cnt;
        @(negedge clk);
        sub = s; a = x; b = y; cin = c; start = 1'b1;
        exp_q.push_back(model(s, x, y, c));
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
            if (spam) begin
                start = 1'b1; sub = $urandom_range(1, 0);
                a = W'($urandom); b = W'($urandom); cin = $urandom_range(1, 0);
            end
            @(posedge clk); #1;
        end
        check("done_latency", 64'(lat), 64'(N));
        check("busy_cycles", 64'(busy_cnt), 64'(N + 1));
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after", {63'd0, busy}, 64'd0);
        check("done_after", {63'd0, done}, 64'd0);
    endtask

    initial begin
        // Reset held with start asserted.
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_sum", {48'd0, sum}, 64'd0);
        check("rst_cout", {63'd0, cout}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", {63'd0, busy}, 64'd0);

        do_op(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0);
        do_op(1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        do_op(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b0);
        do_op(1'b1, 16'h0003, 16'h0005, 1'b0, 1'b0);
        // Starts during RUN/DONE are ignored; next op starts in first IDLE.
        do_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        do_op(1'b0, 16'hA5A5, 16'h5A5A, 1'b1, 1'b0);

        // Abort in the third RUN cycle.
        @(negedge clk);
        sub = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_sum", {48'd0, sum}, 64'd0);
        check("abort_cout", {63'd0, cout}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_idle", {63'd0, busy}, 64'd0);

        for (int i = 0; i < 200; i++) begin
            do_op(1'($urandom_range(1, 0)), W'($urandom), W'($urandom),
                  1'($urandom_range(1, 0)), 1'b0);
        end

        repeat (4) @(negedge clk);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
